// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the VGA output path.
// Produces pixel coordinates, the active-video flag and line/frame pulses
// from pix_ce-gated counters, plus sync/DE outputs delayed by DELAY clocks
// so they line up with a registered pattern block.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned DELAY    = 1,
  parameter int unsigned CW       = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pix_ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          enable,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [CW-1:0] h_next, v_next;
  logic          enable_q, enable_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Next-position decode; flags are decoded from the next counter values
  // so they stay coherent with hcount/vcount in the same cycle.
  always_comb begin
    h_next = hcount_q;
    v_next = vcount_q;
    if (hcount_q < H_LAST) begin
      h_next = hcount_q + CW'(1);
    end else begin
      h_next = '0;
      v_next = (vcount_q < V_LAST) ? vcount_q + CW'(1) : '0;
    end

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    enable_d      = enable_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      hcount_d      = h_next;
      vcount_d      = v_next;
      enable_d      = (h_next < H_ACT) && (v_next < V_ACT);
      hsync_d       = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (h_next == '0);
      frame_start_d = (h_next == '0) && (v_next == '0);
    end
  end

  // Counter and decoded-flag registers; reset parks at the last position
  // so the first pix_ce wraps to (0,0).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      enable_q      <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      enable_q      <= enable_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign enable      = enable_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

  generate
    if (DELAY == 0) begin : g_direct
      assign de_o    = enable_q;
      assign hsync_o = hsync_q;
      assign vsync_o = vsync_q;
    end else begin : g_pipe
      // Each stage holds {enable, hsync, vsync}; stage 0 of the shift
      // vector is the live internal value, stage DELAY is the output.
      logic [DELAY:1][2:0] pipe_q;
      logic [DELAY:1][2:0] pipe_d;
      logic [DELAY:0][2:0] shift;

      // Shift one stage per clock, regardless of pix_ce.
      always_comb begin
        shift  = {pipe_q, enable_q, hsync_q, vsync_q};
        pipe_d = shift[DELAY-1:0];
      end

      // Delay-line registers, reset to the inactive levels.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          pipe_q <= {DELAY{1'b0, ~SYNC_POL, ~SYNC_POL}};
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign de_o    = pipe_q[DELAY][2];
      assign hsync_o = pipe_q[DELAY][1];
      assign vsync_o = pipe_q[DELAY][0];
    end
  endgenerate

endmodule
